aes_feedback_cipher: RTL and testbench

//  Byte-serial 8-bit feedback (CBC-style) cipher built on the AES S-box; encrypts or decrypts one byte per handshake.

---
 rtl/aes_fb_pkg.sv | 40 ++++
 rtl/aes_sbox8.sv | 10 +
 rtl/aes_feedback_cipher.sv | 40 ++++
 tb/tb_aes_feedback_cipher.sv | 101 ++++++++++
 4 files changed

// File: rtl/aes_fb_pkg.sv
// aes_fb_pkg: AES forward/inverse S-box tables and default feedback IV
package aes_fb_pkg;
  localparam logic [7:0] IV_DEFAULT = 8'h00;
  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };
  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
    8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
    8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
    8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
    8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
    8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
    8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
    8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
    8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
    8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
    8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
    8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
    8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
    8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
    8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
    8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
  };
endpackage

// File: rtl/aes_sbox8.sv
// aes_sbox8: combinational AES S-box lookup, inverse when inv=1
module aes_sbox8
  import aes_fb_pkg::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);
  assign dout = inv ? INV_SBOX[din] : SBOX[din];
endmodule

// File: rtl/aes_feedback_cipher.sv
// aes_feedback_cipher: byte-serial CBC-style S-box cipher; AFC_PULSE_READY_EN makes out_ready a one-cycle pulse
module aes_feedback_cipher
  import aes_fb_pkg::*;
#(
  parameter logic [7:0] IV = IV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key,
  input  logic [7:0] in_msg,
  input  logic       new_msg,
  input  logic       enc_dec,
  input  logic       in_valid,
  output logic [7:0] out_msg,
  output logic       out_ready
);
  logic [7:0] fb, fb_use, pre, sb, res;
  assign fb_use = new_msg ? IV : fb;
  assign pre = enc_dec ? in_msg ^ fb_use ^ key : in_msg;
  assign res = enc_dec ? sb : sb ^ fb_use ^ key;
  aes_sbox8 u_sbox (.din(pre), .inv(!enc_dec), .dout(sb));
  // fb always tracks the ciphertext side; out_msg holds the last result
  always_ff @(posedge clk) begin
    if (rst) begin
      fb <= IV;
      out_msg <= 8'h00;
      out_ready <= 1'b0;
    end else if (in_valid) begin
      fb <= enc_dec ? sb : in_msg;
      out_msg <= res;
      out_ready <= 1'b1;
    end else if (new_msg) begin
      fb <= IV;
      out_ready <= 1'b0;
    end
`ifdef AFC_PULSE_READY_EN
    else out_ready <= 1'b0;
`endif
  end
endmodule

// File: tb/tb_aes_feedback_cipher.sv
// tb_aes_feedback_cipher: scoreboard bench with an arithmetic GF(2^8) S-box model
module tb_aes_feedback_cipher;
  logic clk = 1'b0;
  logic rst, new_msg, enc_dec, in_valid, out_ready;
  logic [7:0] key, in_msg, out_msg;
  int total = 0, bad = 0;
  logic [7:0] q[$];
  logic [7:0] pt[10], ct[10];
  logic [7:0] fbm, last;
  aes_feedback_cipher dut (.clk(clk), .rst(rst), .key(key), .in_msg(in_msg), .new_msg(new_msg),
    .enc_dec(enc_dec), .in_valid(in_valid), .out_msg(out_msg), .out_ready(out_ready));
  always #5 clk = ~clk;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [7:0] msbox(input logic [7:0] x);
    logic [7:0] b = 8'h00;
    for (int i = 1; i < 256; i++) if (x != 8'h00 && gmul(x, 8'(i)) == 8'h01) b = 8'(i);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%02h want=%02h", n, a, e);
    end
  endtask
  task automatic byte_in(input logic [7:0] k, input logic [7:0] m, input logic ed, input logic nm, input logic [7:0] e);
    q.push_back(e);
    last = e;
    key = k; in_msg = m; enc_dec = ed; new_msg = nm; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; new_msg = 1'b0;
  endtask
  logic mr = 1'b0, armed = 1'b0;
  // monitor: model the ready flag every cycle and pop expected bytes on each accepted input
  always begin
    logic acc, nm, r;
    @(posedge clk);
    acc = in_valid && !rst; nm = new_msg; r = rst;
    if (r) mr = 1'b0;
    else if (acc) mr = 1'b1;
    else if (nm) mr = 1'b0;
`ifdef AFC_PULSE_READY_EN
    else mr = 1'b0;
`endif
    if (r) armed = 1'b1;
    #1;
    if (armed) chk("ready", {7'd0, out_ready}, {7'd0, mr});
    if (acc) begin
      if (q.size() == 0) chk("sb_empty", 8'h01, 8'h00);
      else chk("out_msg", out_msg, q.pop_front());
    end
  end
  initial begin
    rst = 1'b1; in_valid = 1'b0; new_msg = 1'b0; enc_dec = 1'b1; key = 8'h00; in_msg = 8'h00;
    if (msbox(8'h00) != 8'h63 || msbox(8'hA5) != 8'h06) $display("note: S-box model disagrees with FIPS-197 samples");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_msg", out_msg, 8'h00);
    chk("rst_ready", {7'd0, out_ready}, 8'h00);
    byte_in(8'hA5, 8'h00, 1'b1, 1'b1, 8'h06);
    byte_in(8'hA5, 8'h00, 1'b1, 1'b0, 8'h0A);
    repeat (2) @(negedge clk);
    chk("hold_msg", out_msg, 8'h0A);
    byte_in(8'hA5, 8'h06, 1'b0, 1'b1, 8'h00);
    byte_in(8'hA5, 8'h0A, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    new_msg = 1'b1;
    @(negedge clk);
    new_msg = 1'b0;
    chk("nm_hold_msg", out_msg, last);
    byte_in(8'h00, 8'h00, 1'b1, 1'b1, 8'h63);
    fbm = 8'h00;
    for (int i = 0; i < 10; i++) begin
      pt[i] = 8'($urandom_range(0, 255));
      ct[i] = msbox(pt[i] ^ fbm);
      fbm = ct[i];
      byte_in(8'h00, pt[i], 1'b1, i == 0, ct[i]);
    end
    for (int i = 0; i < 10; i++) byte_in(8'h00, ct[i], 1'b0, i == 0, pt[i]);
    byte_in(8'hA5, 8'h33, 1'b1, 1'b0, msbox(8'h33 ^ ct[9] ^ 8'hA5));
    byte_in(8'hA5, 8'h00, 1'b1, 1'b1, 8'h06);
    byte_in(8'hA5, 8'h00, 1'b1, 1'b0, 8'h0A);
    key = 8'hA5; in_msg = 8'h00; enc_dec = 1'b1; in_valid = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_msg", out_msg, 8'h00);
    chk("mid_rst_ready", {7'd0, out_ready}, 8'h00);
    byte_in(8'hA5, 8'h00, 1'b1, 1'b0, 8'h06);
    repeat (3) @(negedge clk);
    chk("sb_drained", 8'(q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
